// File: rtl/mem_rr_arb_4m1s_if.sv
// Purpose: bundle of the four-master request/response bus and the single slave port.
// Latency: wires only, no state.
// Backpressure: carried by s_ack_i (accept) and the outstanding-read count in outst_o.
interface mem_rr_arb_4m1s_if #(
  parameter int OUTST_DEPTH = 4
);
  localparam int CW = $clog2(OUTST_DEPTH) + 1;

  // master side
  logic [3:0]        m_req_i;
  logic [3:0]        m_we_i;
  logic [3:0][31:0]  m_addr_i;
  logic [3:0][3:0]   m_be_i;
  logic [3:0][31:0]  m_wdata_i;
  logic [3:0]        m_ack_o;
  logic [3:0]        m_resp_o;
  logic [31:0]       m_rdata_o;

  // slave side
  logic              s_req_o;
  logic              s_we_o;
  logic [31:0]       s_addr_o;
  logic [3:0]        s_be_o;
  logic [31:0]       s_wdata_o;
  logic              s_ack_i;
  logic              s_resp_i;
  logic [31:0]       s_rdata_i;

  // status
  logic [CW-1:0]     outst_o;
  logic              err_o;

  // Arbiter's view.
  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i,
    input  s_ack_i, s_resp_i, s_rdata_i,
    output m_ack_o, m_resp_o, m_rdata_o,
    output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
    output outst_o, err_o
  );

  // Environment's view (masters plus memory).
  modport master (
    output m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i,
    output s_ack_i, s_resp_i, s_rdata_i,
    input  m_ack_o, m_resp_o, m_rdata_o,
    input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
    input  outst_o, err_o
  );
endinterface

// File: rtl/mem_rr_arb_4m1s.sv
// Purpose: 4-master to 1-slave round-robin memory arbiter with in-order read response routing.
// Latency: request and ack pass through combinationally (0 cycles); responses route in the same cycle.
// Backpressure: s_ack_i low locks the grant; reads stall while OUTST_DEPTH reads are outstanding.
module mem_rr_arb_4m1s #(
  parameter int OUTST_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_rr_arb_4m1s_if.slave  bus
);
  localparam int AW = $clog2(OUTST_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [1:0]    lock_id;
  logic [1:0]    rr_ptr;
  logic [1:0]    fifo_mem [OUTST_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          err;

  logic [1:0]    grant;
  logic          gvld;
  logic          read_ok;
  logic          s_req;
  logic          accept;
  logic          push;
  logic          pop;
  logic [1:0]    head;

  // Grant selection: the locked master, or the first requester at/after rr_ptr.
  always_comb begin
    grant = lock_id;
    gvld  = 1'b0;
    if (state == LOCKED) begin
      grant = lock_id;
      gvld  = bus.m_req_i[lock_id];
    end else begin
      // Walk from the farthest offset down so the nearest requester wins.
      for (int i = 3; i >= 0; i--) begin
        if (bus.m_req_i[rr_ptr + 2'(i)]) begin
          grant = rr_ptr + 2'(i);
          gvld  = 1'b1;
        end
      end
    end
  end

  // Reads look only at the registered count, so a same-cycle pop cannot unblock them.
  assign read_ok = (cnt < CW'(OUTST_DEPTH));
  assign s_req   = rst_i & gvld & (bus.m_we_i[grant] | read_ok);
  assign accept  = s_req & bus.s_ack_i;
  assign push    = accept & ~bus.m_we_i[grant];
  assign pop     = rst_i & bus.s_resp_i & (cnt != '0);
  assign head    = fifo_mem[rd_ptr];

  assign bus.s_req_o   = s_req;
  assign bus.s_we_o    = s_req & bus.m_we_i[grant];
  assign bus.s_addr_o  = s_req ? bus.m_addr_i[grant]  : '0;
  assign bus.s_be_o    = s_req ? bus.m_be_i[grant]    : '0;
  assign bus.s_wdata_o = s_req ? bus.m_wdata_i[grant] : '0;
  assign bus.m_ack_o   = accept ? (4'b0001 << grant) : 4'b0000;
  assign bus.m_resp_o  = pop ? (4'b0001 << head) : 4'b0000;
  assign bus.m_rdata_o = pop ? bus.s_rdata_i : '0;
  assign bus.outst_o   = cnt;
  assign bus.err_o     = err;

  // Lock FSM, round-robin pointer, FIFO pointers, outstanding count and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      lock_id <= 2'd0;
      rr_ptr  <= 2'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_req && !bus.s_ack_i) begin
            state   <= LOCKED;
            lock_id <= grant;
          end
        end
        LOCKED: begin
          // Either accepted, or the locked master withdrew / became ineligible.
          if (!s_req || bus.s_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) rr_ptr <= grant + 2'd1;
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);

      if (bus.s_resp_i && cnt == '0) err <= 1'b1;
    end
  end

  // ID storage: records which master owns each accepted read, in acceptance order.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= grant;
  end
endmodule
